impaired_channel_fifo: RTL and testbench

//  Parametrised FIFO that emulates an impaired network link between producer and consumer.

---
 rtl/impaired_channel_fifo.sv | 124 ++++++++++++
 tb/tb_impaired_channel_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/impaired_channel_fifo.sv
// FIFO that emulates a lossy, jittery link: optional LFSR-driven per-pop read delay and
// LFSR-driven write drops, behind a plain wr_en/full, rd_en/empty/dout interface.
module impaired_channel_fifo #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] RD_SEED = 32'h3ADE68B1,
  parameter logic [31:0] WR_SEED = 32'h1F2E3D4C
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [1:0]        mode,
  input  logic [7:0]        delay_mask,
  input  logic [7:0]        drop_thresh,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [15:0]       drop_cnt
);

  localparam int            DEPTH_N   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [31:0]   LFSR_MASK = 32'h80200003;

  // Galois step for x^32+x^22+x^2+x+1, shifting right.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] sh;
    sh = {1'b0, s[31:1]};
    if (s[0]) begin
      lfsr_next = sh ^ LFSR_MASK;
    end else begin
      lfsr_next = sh;
    end
  endfunction

  logic [DATA_W-1:0] mem_r [0:DEPTH_N-1];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r, count_next_s;
  logic [7:0]        dly_r, dly_next_s;
  logic [31:0]       rd_lfsr_r, wr_lfsr_r;
  logic [15:0]       drop_cnt_r;
  logic [DATA_W-1:0] dout_r;
  logic              dout_valid_r;
  logic              wr_acc_s, drop_hit_s, wr_store_s, pop_s, wait_s;

  assign empty      = (count_r == {(ADDR_W + 1){1'b0}});
  assign full       = (count_r == DEPTH);
  assign count      = count_r;
  assign drop_cnt   = drop_cnt_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

  // Write acceptance/drop decision, pop/wait decision, and next delay and count.
  always_comb begin
    wr_acc_s     = wr_en && !full;
    drop_hit_s   = mode[1] && ((drop_thresh == 8'hFF) || (wr_lfsr_r[7:0] < drop_thresh));
    wr_store_s   = wr_acc_s && !drop_hit_s;
    pop_s        = rd_en && !empty && (dly_r == 8'd0);
    wait_s       = rd_en && !empty && (dly_r != 8'd0);
    dly_next_s   = dly_r;
    count_next_s = count_r;
    if (!mode[0]) begin
      dly_next_s = 8'd0;
    end else if (pop_s) begin
      dly_next_s = rd_lfsr_r[7:0] & delay_mask;
    end else if (wait_s) begin
      dly_next_s = dly_r - 8'd1;
    end else begin
      dly_next_s = dly_r;
    end
    case ({wr_store_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_store_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, count, delay, LFSRs, drop counter and registered read port.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      dly_r        <= 8'd0;
      rd_lfsr_r    <= RD_SEED;
      wr_lfsr_r    <= WR_SEED;
      drop_cnt_r   <= 16'd0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      count_r      <= count_next_s;
      dly_r        <= dly_next_s;
      dout_valid_r <= pop_s;
      dout_r       <= pop_s ? mem_r[rd_ptr_r] : '0;
      if (wr_acc_s) begin
        wr_lfsr_r <= lfsr_next(wr_lfsr_r);
      end
      if (wr_store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (wr_acc_s && drop_hit_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_lfsr_r <= lfsr_next(rd_lfsr_r);
      end
    end
  end

endmodule

// File: tb/tb_impaired_channel_fifo.sv
// Bench for impaired_channel_fifo: directed table, corner sequences and randomized traffic
// compared every cycle against a queue-based reference model.
module tb_impaired_channel_fifo;

  localparam logic [31:0] RD_SEED = 32'h3ADE68B1;
  localparam logic [31:0] WR_SEED = 32'h1F2E3D4C;

  logic        clk, srst, wr_en, rd_en, dout_valid, empty, full;
  logic [7:0]  din, dout, delay_mask, drop_thresh;
  logic [1:0]  mode;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  impaired_channel_fifo #(.DATA_W(8), .ADDR_W(4), .RD_SEED(RD_SEED), .WR_SEED(WR_SEED)) dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .mode(mode),
    .delay_mask(delay_mask), .drop_thresh(drop_thresh), .dout(dout), .dout_valid(dout_valid),
    .empty(empty), .full(full), .count(count), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  logic [7:0]  mq[$];
  logic [7:0]  m_dly;
  logic [31:0] m_rl, m_wl;
  logic [15:0] m_drop;
  logic [7:0]  m_dout;
  logic        m_valid;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       exp_v;
    logic [7:0] exp_dout;
    int         exp_cnt;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dly = 8'd0; m_rl = RD_SEED; m_wl = WR_SEED; m_drop = 16'd0;
    m_dout = 8'd0; m_valid = 1'b0;
  endtask

  task automatic compare_all();
    chk("dout", 32'({dout_valid, dout}), 32'({m_valid, m_dout}));
    chk("count", 32'(count), 32'(mq.size()));
    chk("flags", 32'({empty, full}), 32'({mq.size() == 0, mq.size() == 16}));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // one clock: drive, advance the model from the pre-edge state, then compare
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bit m_empty, m_full, pop, waitc, hit;
    wr_en = w; din = d; rd_en = r;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == 16);
    pop     = r && !m_empty && (m_dly == 8'd0);
    waitc   = r && !m_empty && (m_dly != 8'd0);
    m_valid = pop;
    m_dout  = pop ? mq.pop_front() : 8'd0;
    if (!mode[0]) m_dly = 8'd0;
    else if (pop) m_dly = m_rl[7:0] & delay_mask;
    else if (waitc) m_dly = m_dly - 8'd1;
    if (pop) m_rl = galois(m_rl);
    if (w && !m_full) begin
      hit = mode[1] && ((drop_thresh == 8'hFF) || (m_wl[7:0] < drop_thresh));
      m_wl = galois(m_wl);
      if (hit) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        mq.push_back(d);
      end
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; srst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    srst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int ptimes[$];
    logic [31:0] l;
    srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    mode = 2'b00; delay_mask = 8'h00; drop_thresh = 8'h00;
    model_reset();

    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 8'h00, i + 1};
    for (int i = 0; i < 5; i++) tbl[5 + i] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'(i + 1), 4 - i};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

    // T1 pass-through table
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk("t1_dout", 32'({dout_valid, dout}), 32'({tbl[i].exp_v, tbl[i].exp_dout}));
      chk("t1_count", 32'(count), 32'(tbl[i].exp_cnt));
    end
    chk("t1_empty", 32'(empty), 32'd1);

    // T2 full and pointer wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 15) chk("t2_full", 32'(full), 32'd1);
    end
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_drop", 32'(drop_cnt), 32'd0);
    drain(8);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
    drain(17);

    // T3 simultaneous push/pop
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA3 + i), 1'b1);
    chk("t3_count", 32'(count), 32'd3);
    drain(4);

    // T4 delay with zero mask behaves as pass-through
    mode = 2'b01; delay_mask = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    drain(4);

    // T5 drops
    do_reset();
    mode = 2'b10; drop_thresh = 8'hFF;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
    chk("t5_count_all_drop", 32'(count), 32'd0);
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd20);
    drop_thresh = 8'h00;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    chk("t5_count_no_drop", 32'(count), 32'd5);
    chk("t5_drop_hold", 32'(drop_cnt), 32'd20);

    // T6 reset in the middle of a long delay
    do_reset();
    mode = 2'b01; delay_mask = 8'hFF;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    drain(4);
    do_reset();
    chk("t6_empty", 32'(empty), 32'd1);

    // T4 gaps: first delay after reset comes from RD_SEED
    mode = 2'b01; delay_mask = 8'h07;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 8'h00, 1'b1);
      if (dout_valid) ptimes.push_back(c);
    end
    chk("t4_pops", 32'(ptimes.size()), 32'd4);
    l = RD_SEED;
    for (int k = 1; k < ptimes.size(); k++) begin
      chk("t4_gap", 32'(ptimes[k] - ptimes[k - 1]), 32'((l[7:0] & 8'h07) + 8'd1));
      l = galois(l);
    end

    // randomized traffic with occasional config changes and a mid-run reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mode = 2'($urandom_range(0, 3));
        delay_mask = 8'($urandom_range(0, 255)) & 8'h0F;
        drop_thresh = 8'($urandom_range(0, 255));
      end
      if (i == 400) do_reset();
      step($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
